// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send on the shared open-drain pair,
// clocks out one byte plus parity and stop, then collects the device ACK.
module ps2_host_tx #(
    parameter int unsigned CLK_INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES     = 750000,
    parameter int unsigned CNT_W              = 20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_done,
    output logic       tx_ack_err,
    output logic       tx_timeout
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQ       = 3'd2,
        S_SEND      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(CLK_INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    state_e          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]      bit_cnt_q;
    logic [9:0]      shift_q;
    logic            nack_q;
    logic            clk_oe_q;
    logic            data_oe_q;
    logic            done_q;
    logic            ack_err_q;
    logic            timeout_q;
    logic [2:0]      clk_sync_q;
    logic [2:0]      data_sync_q;

    logic            fall_s;
    logic            data_s;
    logic            idle_s;
    logic            watch_s;
    logic            timeout_s;

    // Three-flop synchronisers; reset to the released (high) line level
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 3'b111;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
            data_sync_q <= {data_sync_q[1:0], ps2_data};
        end
    end

    assign fall_s    = clk_sync_q[2] & ~clk_sync_q[1];
    assign data_s    = data_sync_q[1];
    // Bus counts as idle only once both lines have read high for two samples
    assign idle_s    = &{clk_sync_q[2:1], data_sync_q[2:1]};
    assign watch_s   = (state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
    assign timeout_s = watch_s && !fall_s && (cnt_q == TIMEOUT_LAST);

    // Transmit sequencer with registered line enables and status
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= 4'd0;
            shift_q   <= 10'd0;
            nack_q    <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (timeout_s) begin
                clk_oe_q  <= 1'b0;
                data_oe_q <= 1'b0;
                done_q    <= 1'b1;
                ack_err_q <= 1'b1;
                timeout_q <= 1'b1;
                cnt_q     <= '0;
                state_q   <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (tx_valid) begin
                            shift_q   <= {1'b1, odd_parity(tx_data), tx_data};
                            cnt_q     <= '0;
                            bit_cnt_q <= 4'd0;
                            clk_oe_q  <= 1'b1;
                            data_oe_q <= 1'b0;
                            state_q   <= S_INHIBIT;
                        end else begin
                            clk_oe_q  <= 1'b0;
                            data_oe_q <= 1'b0;
                        end
                    end
                    S_INHIBIT: begin
                        if (cnt_q == INHIBIT_LAST) begin
                            cnt_q     <= '0;
                            data_oe_q <= 1'b1;
                            state_q   <= S_REQ;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    S_REQ: begin
                        // Release clock; data stays low as the start bit
                        clk_oe_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= S_SEND;
                    end
                    S_SEND: begin
                        if (fall_s) begin
                            cnt_q     <= '0;
                            data_oe_q <= ~shift_q[0];
                            shift_q   <= {1'b0, shift_q[9:1]};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd9) begin
                                state_q <= S_ACK;
                            end else begin
                                state_q <= S_SEND;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    S_ACK: begin
                        data_oe_q <= 1'b0;
                        if (fall_s) begin
                            nack_q  <= data_s;
                            cnt_q   <= '0;
                            state_q <= S_WAIT_IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (idle_s) begin
                            done_q    <= 1'b1;
                            ack_err_q <= nack_q;
                            timeout_q <= 1'b0;
                            cnt_q     <= '0;
                            state_q   <= S_IDLE;
                        end else if (fall_s) begin
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ready    = (state_q == S_IDLE);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;
    assign tx_ack_err  = ack_err_q;
    assign tx_timeout  = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple open-drain device model
// clocking at a 40-cycle period.
module tb_ps2_host_tx;

    localparam int INH  = 16;
    localparam int TO   = 200;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       resetn;
    logic       dev_clk;
    logic       dev_data;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       tx_done;
    logic       tx_ack_err;
    logic       tx_timeout;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Wired-AND pads: either side can pull a line low
    assign ps2_clk  = dev_clk & ~ps2_clk_oe;
    assign ps2_data = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .CLK_INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES    (TO),
        .CNT_W             (20)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_done    (tx_done),
        .tx_ack_err (tx_ack_err),
        .tx_timeout (tx_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts cycles with only the clock held low, then checks the request cycle
    task automatic inhibit_check();
        int n;
        n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("inhibit_len", n, INH);
        chk("req_clk_oe", ps2_clk_oe, 1);
        chk("req_data_oe", ps2_data_oe, 1);
        @(negedge clk);
        chk("send_clk_released", ps2_clk_oe, 0);
        chk("send_start_bit", ps2_data_oe, 1);
    endtask

    task automatic start_tx(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("ready_low_after_capture", tx_ready, 0);
        inhibit_check();
    endtask

    // Device side of one frame: 11 samples on rising edges, then ACK slot
    task automatic dev_frame(input logic [7:0] b, input bit do_ack, input bit busy);
        logic [10:0] got;
        logic [10:0] want;
        int          n;
        want = {1'b1, ~^b, b, 1'b0};
        got  = 11'd0;
        if (busy) begin
            tx_data  = 8'hAA;
            tx_valid = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        if (busy) begin
            chk("busy_ready_low", tx_ready, 0);
            chk("busy_clk_released", ps2_clk_oe, 0);
        end
        got[0] = ps2_data;
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            got[k]  = ps2_data;
            repeat (HALF) @(negedge clk);
        end
        chk("frame_bits", got, want);
        chk("ack_data_released", ps2_data_oe, 0);
        if (do_ack) dev_data = 1'b0;
        repeat (5) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        n = 0;
        while (!tx_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", tx_done, 1);
        chk("done_ack_err", tx_ack_err, do_ack ? 0 : 1);
        chk("done_timeout", tx_timeout, 0);
        chk("done_ready", tx_ready, 1);
        @(negedge clk);
        chk("done_one_cycle", tx_done, 0);
        chk("ack_err_hold", tx_ack_err, do_ack ? 0 : 1);
    endtask

    initial begin
        resetn   = 1'b0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_ack_err", tx_ack_err, 0);
        chk("rst_timeout", tx_timeout, 0);
        chk("rst_ready", tx_ready, 1);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ready", tx_ready, 1);
        chk("idle_clk_oe", ps2_clk_oe, 0);

        // 0xED: even number of ones, parity 1, ACKed
        start_tx(8'hED);
        dev_frame(8'hED, 1'b1, 1'b0);

        // 0x01 (parity 0) with a 0xAA request held throughout
        start_tx(8'h01);
        dev_frame(8'h01, 1'b1, 1'b1);
        chk("busy_capture_clk_oe", ps2_clk_oe, 1);
        chk("busy_capture_ready", tx_ready, 0);
        tx_valid = 1'b0;
        inhibit_check();
        dev_frame(8'hAA, 1'b1, 1'b0);

        // NACK: data left high in the ACK slot
        start_tx(8'h00);
        dev_frame(8'h00, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("nack_hold", tx_ack_err, 1);

        // Timeout: device stops after the third clock pulse
        start_tx(8'h5A);
        repeat (HALF) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        // Fall is seen 3 cycles after the pad drops, timeout TO cycles later
        repeat (TO + 2 - HALF) @(negedge clk);
        chk("to_not_early", tx_done, 0);
        chk("to_data_oe_held", ps2_data_oe, 1);
        @(negedge clk);
        chk("to_done", tx_done, 1);
        chk("to_flag", tx_timeout, 1);
        chk("to_ack_err", tx_ack_err, 1);
        chk("to_clk_oe", ps2_clk_oe, 0);
        chk("to_data_oe", ps2_data_oe, 0);
        @(negedge clk);
        chk("to_ready_next", tx_ready, 1);
        chk("to_done_one_cycle", tx_done, 0);

        // Asynchronous reset in the middle of SEND while data is driven low
        start_tx(8'h00);
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        chk("mid_send_data_oe", ps2_data_oe, 1);
        resetn = 1'b0;
        #1;
        chk("async_rst_clk_oe", ps2_clk_oe, 0);
        chk("async_rst_data_oe", ps2_data_oe, 0);
        chk("async_rst_ack_err", tx_ack_err, 0);
        chk("async_rst_timeout", tx_timeout, 0);
        chk("async_rst_ready", tx_ready, 1);
        dev_clk = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_ready", tx_ready, 1);
        chk("post_rst_clk_oe", ps2_clk_oe, 0);
        chk("post_rst_data_oe", ps2_data_oe, 0);
        chk("post_rst_done", tx_done, 0);

        // Asynchronous reset while the clock line is inhibited
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("inhibit_clk_oe", ps2_clk_oe, 1);
        resetn = 1'b0;
        #1;
        chk("inhibit_rst_clk_oe", ps2_clk_oe, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("inhibit_rst_ready", tx_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter; the send-side companion to the existing ps2_keyboard receiver on the same ps2_clk/ps2_data pair.
- Sends command bytes (LED set 0xED, reset 0xFF, typematic 0xF3, ...) to the keyboard using the open-drain request-to-send sequence.
- Accepts one byte through a valid/ready handshake and reports completion, device ACK status and timeout.
- Sits beside ps2_keyboard in top; top combines the *_oe outputs into the bidirectional pads.

Parameters:
- CLK_INHIBIT_CYCLES, 5000, system clocks that ps2_clk is held low before the request (≥100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, max system clocks between consecutive device ps2_clk falling edges before abort (15 ms).
- CNT_W, 20, width of the shared inhibit/timeout counter; must hold max(CLK_INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk in 1 system clock; all logic on posedge.
- resetn in 1 asynchronous active-low reset.
- ps2_clk in 1 raw pad level of PS/2 clock.
- ps2_data in 1 raw pad level of PS/2 data.
- tx_data in 8 byte to send; captured when tx_valid & tx_ready.
- tx_valid in 1 request strobe.
- tx_ready out 1 high only in IDLE.
- ps2_clk_oe out 1 1 = drive ps2_clk low; 0 = release.
- ps2_data_oe out 1 1 = drive ps2_data low; 0 = release.
- tx_done out 1 one-cycle pulse at end of every attempt: ACK, NACK or timeout.
- tx_ack_err out 1 valid with tx_done; 1 = device did not ACK.
- tx_timeout out 1 valid with tx_done; 1 = aborted on timeout.

Behaviour:
- Reset (async, resetn=0): state IDLE; ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_ack_err=0, tx_timeout=0; tx_ready=1 once in IDLE; counters and shift register cleared. Lines are released on the same edge reset asserts, including mid-frame.
- Input sync: ps2_clk and ps2_data each pass through a 3-flop synchroniser. fall = (stage2==1 && stage1==0). Sampled ps2_data = stage1.
- Frame: shift register {1 (stop), odd parity = ~^tx_data, tx_data[7:0]}; driven LSB first.
- IDLE: tx_ready=1. On tx_valid: capture byte, clear counter, go to INHIBIT. tx_valid while not in IDLE is ignored.
- INHIBIT: ps2_clk_oe=1 for exactly CLK_INHIBIT_CYCLES cycles, then go to REQ.
- REQ: ps2_clk_oe=1 and ps2_data_oe=1 for one cycle (start bit = 0), then go to SEND.
- SEND: ps2_clk_oe=0. ps2_data_oe holds low until the first fall.
  - On each fall: ps2_data_oe = ~shift[0], shift right, bit count +1.
  - The 10th fall drives the stop bit, which releases data. Then go to ACK.
- ACK: ps2_data_oe=0. On the next fall, sample data: 0 = ACK (tx_ack_err=0), 1 = NACK (tx_ack_err=1). Then go to WAIT_IDLE.
- WAIT_IDLE: wait until synced clk=1 and data=1, then pulse tx_done for one cycle and return to IDLE.
- Timeout:
  - The counter clears on every fall and on entry to SEND.
  - If it reaches TIMEOUT_CYCLES in SEND, ACK or WAIT_IDLE: release both lines, pulse tx_done with tx_timeout=1 and tx_ack_err=1, return to IDLE.
- Output timing: tx_done, tx_ack_err and tx_timeout are registered and valid together in the tx_done cycle. tx_ack_err and tx_timeout hold their value until the next tx_done.
- Latency: the earliest tx_done is CLK_INHIBIT_CYCLES + 1 + (11 device clock periods) + sync delay.
- Receiver interaction: ps2_keyboard also sees the frame on the shared lines. Discarding that data is top's job, not this block's.

Test Plan:
- Reset: resetn=0 mid-SEND → ps2_clk_oe=0 and ps2_data_oe=0 immediately (no clock edge needed); after release, tx_ready=1 and the outputs keep their reset values.
- Send 0xED with CLK_INHIBIT_CYCLES=16 and a device model clocking at a 40-cycle period:
  - ps2_clk_oe high exactly 16 cycles, then 1 cycle with both lines low.
  - Device samples on rising edges: 0, 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Device ACKs → tx_done=1, tx_ack_err=0, tx_timeout=0.
- Send 0x01 → parity bit 0.
- NACK: send 0x00 (parity 1); device leaves data high at the ACK slot → tx_done with tx_ack_err=1, tx_timeout=0.
- Timeout: TIMEOUT_CYCLES=200; device stops clocking after bit 3 → tx_done exactly 200 cycles after the last fall, tx_timeout=1, both oe=0, tx_ready=1 the next cycle.
- Busy: tx_valid with 0xAA while in SEND → ignored and tx_ready=0; the in-flight byte completes unchanged; tx_valid held through return to IDLE → 0xAA is captured on the first tx_ready cycle.
